// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add is split into STAGES slices of WIDTH/STAGES bits; each
// register stage adds one slice and forwards its carry to the next stage.
// Operand bits not yet consumed and result bits already produced travel with
// the beat, so each stage only stores what later stages still need.
// A single global advance signal stalls every stage when the output is held.
// Optional build macro: PIPE_ADDER_SAT_EN -- when defined, the final stage
// clamps sum to the signed limits on overflow (cout/ovf stay unsaturated).
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S = WIDTH / STAGES;

    logic w_advance;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // operand bits still to be added when this stage sees the beat
        localparam int OW = WIDTH - k * S;

        logic [OW-1:0]      w_a_src;
        logic [OW-1:0]      w_b_src;
        logic               w_c_src;
        logic               w_v_src;
        logic [S:0]         w_slice;
        logic [k*S+S-1:0]   w_sum_new;

        if (k == 0) begin : g_in
            // subtract is a + ~b + 1, so the carry-in is forced to 1
            assign w_a_src   = a;
            assign w_b_src   = sub ? ~b : b;
            assign w_c_src   = sub ? 1'b1 : cin;
            assign w_v_src   = in_valid;
            assign w_sum_new = w_slice[S-1:0];
        end else begin : g_mid
            assign w_a_src   = g_stage[k-1].g_hold.r_a;
            assign w_b_src   = g_stage[k-1].g_hold.r_b;
            assign w_c_src   = g_stage[k-1].g_hold.r_carry;
            assign w_v_src   = g_stage[k-1].g_hold.r_valid;
            assign w_sum_new = {w_slice[S-1:0], g_stage[k-1].g_hold.r_sum};
        end

        assign w_slice = {1'b0, w_a_src[S-1:0]} + {1'b0, w_b_src[S-1:0]}
                       + {{S{1'b0}}, w_c_src};

        if (k < STAGES - 1) begin : g_hold
            logic                r_valid;
            logic [OW-S-1:0]     r_a;
            logic [OW-S-1:0]     r_b;
            logic [(k+1)*S-1:0]  r_sum;
            logic                r_carry;

            // intermediate stage: capture slice result and remaining operands
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_a     <= '0;
                    r_b     <= '0;
                    r_sum   <= '0;
                    r_carry <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_v_src;
                    if (w_v_src) begin
                        r_a     <= w_a_src[OW-1:S];
                        r_b     <= w_b_src[OW-1:S];
                        r_sum   <= w_sum_new;
                        r_carry <= w_slice[S];
                    end
                end
            end
        end else begin : g_out
            logic             r_valid;
            logic [WIDTH-1:0] r_sum;
            logic             r_cout;
            logic             r_ovf;
            logic             w_msb_cin;
            logic             w_ovf;
            logic [WIDTH-1:0] w_sum_fin;

            // carry into the MSB is recovered from the MSB sum bit
            assign w_msb_cin = w_a_src[S-1] ^ w_b_src[S-1] ^ w_slice[S-1];
            assign w_ovf     = w_msb_cin ^ w_slice[S];

`ifdef PIPE_ADDER_SAT_EN
            localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;
            localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;

            // on overflow both operands share a sign, which is the true sign
            assign w_sum_fin = !w_ovf ? w_sum_new
                             : (w_a_src[S-1] ? SAT_MIN : SAT_MAX);
`else
            assign w_sum_fin = w_sum_new;
`endif

            // final stage: registered result held while downstream stalls
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
                    r_ovf   <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_v_src;
                    if (w_v_src) begin
                        r_sum  <= w_sum_fin;
                        r_cout <= w_slice[S];
                        r_ovf  <= w_ovf;
                    end
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].g_out.r_valid;
    assign sum       = g_stage[STAGES-1].g_out.r_sum;
    assign cout      = g_stage[STAGES-1].g_out.r_cout;
    assign ovf       = g_stage[STAGES-1].g_out.r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: an 8-bit/2-stage instance and a
// 1-bit/1-stage instance (full-adder truth table).
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       cin, sub, cout, ovf;

    logic p1_in_valid, p1_in_ready, p1_out_valid, p1_out_ready;
    logic p1_a, p1_b, p1_cin, p1_sub, p1_sum, p1_cout, p1_ovf;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipe_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
        .a(p1_a), .b(p1_b), .cin(p1_cin), .sub(p1_sub), .out_valid(p1_out_valid),
        .out_ready(p1_out_ready), .sum(p1_sum), .cout(p1_cout), .ovf(p1_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic [7:0] sat;
        logic       cout;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
        bit         lat;
    } exp_t;

    vec_t vecs[17];
    exp_t cur8, cur1;
    exp_t q8[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // full-adder truth tables indexed by {a,b,cin}
    logic [7:0] fa_sum  = 8'b1001_0110;
    logic [7:0] fa_sat  = 8'b1101_0100;
    logic [7:0] fa_cout = 8'b1110_1000;
    logic [7:0] fa_ovf  = 8'b0100_0010;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // scoreboard: push on acceptance, pop and compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q8.delete();
            q1.delete();
        end else begin
            if (in_valid && in_ready) begin
                e = cur8; e.cyc = cyc; q8.push_back(e);
            end
            if (p1_in_valid && p1_in_ready) begin
                e = cur1; e.cyc = cyc; q1.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (q8.size() == 0) check("dut8_unexpected_out", out_valid, 0);
                else begin
                    e = q8.pop_front();
                    check("dut8_sum", sum, e.sum);
                    check("dut8_cout", cout, e.cout);
                    check("dut8_ovf", ovf, e.ovf);
                    if (e.lat) check("dut8_latency", cyc - e.cyc, 2);
                end
            end
            if (p1_out_valid && p1_out_ready) begin
                if (q1.size() == 0) check("dut1_unexpected_out", p1_out_valid, 0);
                else begin
                    e = q1.pop_front();
                    check("dut1_sum", p1_sum, e.sum);
                    check("dut1_cout", p1_cout, e.cout);
                    check("dut1_ovf", p1_ovf, e.ovf);
                    if (e.lat) check("dut1_latency", cyc - e.cyc, 1);
                end
            end
        end
    end

    task automatic send8(input int idx, input bit lat);
        int t = 0;
        a = vecs[idx].a; b = vecs[idx].b; cin = vecs[idx].cin; sub = vecs[idx].sub;
`ifdef PIPE_ADDER_SAT_EN
        cur8.sum = vecs[idx].sat;
`else
        cur8.sum = vecs[idx].sum;
`endif
        cur8.cout = vecs[idx].cout;
        cur8.ovf  = vecs[idx].ovf;
        cur8.lat  = lat;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("dut8_send_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send1(input int idx);
        int t = 0;
        logic [2:0] v;
        v = 3'(idx);
        p1_a = v[2]; p1_b = v[1]; p1_cin = v[0]; p1_sub = 1'b0;
`ifdef PIPE_ADDER_SAT_EN
        cur1.sum = {7'd0, fa_sat[idx]};
`else
        cur1.sum = {7'd0, fa_sum[idx]};
`endif
        cur1.cout = fa_cout[idx];
        cur1.ovf  = fa_ovf[idx];
        cur1.lat  = 1'b1;
        p1_in_valid = 1'b1;
        @(negedge clk);
        while (!p1_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!p1_in_ready) check("dut1_send_timeout", p1_in_ready, 1);
        @(posedge clk);
        #1 p1_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q8.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_q8_empty", q8.size(), 0);
        check("drain_q1_empty", q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[5]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[6]  = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[8]  = '{8'h3C, 8'h4B, 1'b0, 1'b0, 8'h87, 8'h7F, 1'b0, 1'b1};
        vecs[9]  = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0};
        vecs[11] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 8'h30, 1'b0, 1'b0};
        vecs[12] = '{8'h44, 8'h11, 1'b0, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0};
        vecs[13] = '{8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 8'h10, 1'b1, 1'b0};
        vecs[14] = '{8'h08, 8'h08, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[15] = '{8'h21, 8'h01, 1'b0, 1'b0, 8'h22, 8'h22, 1'b0, 1'b0};
        vecs[16] = '{8'h30, 8'h0F, 1'b0, 1'b0, 8'h3F, 8'h3F, 1'b0, 1'b0};

        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        p1_in_valid = 1'b0; p1_out_ready = 1'b1;
        p1_a = 1'b0; p1_b = 1'b0; p1_cin = 1'b0; p1_sub = 1'b0;
        cur8 = '{8'h00, 1'b0, 1'b0, 0, 1'b0};
        cur1 = '{8'h00, 1'b0, 1'b0, 0, 1'b0};

        // a = b = 0xFF with in_valid=1 during reset must not leak through
        rst_n = 1'b0;
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_dut1_out_valid", p1_out_valid, 0);
        @(posedge clk);
        #1;

        // full-adder truth table on the 1-bit instance
        for (int i = 0; i < 8; i++) send1(i);
        drain();

        // directed add/sub vectors, back-to-back
        for (int i = 0; i < 10; i++) send8(i, 1'b1);
        drain();
        repeat (3) @(posedge clk);
        #1;

        // backpressure: 4 beats, out_ready low for 3 edges once the first result arrives
        fork
            begin
                for (int i = 10; i < 14; i++) send8(i, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_out_valid_held", out_valid, 1);
                    check("bp_sum_held", sum, vecs[10].sum);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // bubbles: alternate valid/idle
        for (int i = 14; i < 17; i++) begin
            send8(i, 1'b1);
            @(posedge clk);
            #1;
        end
        drain();

        // reset with two beats in flight: neither may ever emerge
        send8(0, 1'b1);
        send8(1, 1'b1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ovf", ovf, 0);
        repeat (6) @(negedge clk);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
